pio_sm_sequencer: RTL

//  Per-state-machine sequencer for the PIO program counter. Chooses the instruction slot
//  (memory, EXEC, host-forced), counts delay cycles and stalls, and drives the PC's

---
 rtl/pio_pkg.sv | 21 ++
 rtl/pio_delay_counter.sv | 40 ++++
 rtl/pio_sm_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// Shared encodings for the PIO state-machine sequencer: widths, slot sources,
// sequencer states and the position of the delay/side-set field.
package pio_pkg;
  localparam int PIO_ADDR_W  = 5;
  localparam int PIO_INSTR_W = 16;
  localparam int PIO_DELAY_W = 5;
  localparam int DELAY_LSB   = 8;
  localparam int DELAY_MSB   = 12;

  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_EXEC = 2'd1,
    SRC_IMM  = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DELAY = 2'd2
  } state_e;
endpackage

// File: rtl/pio_delay_counter.sv
// Delay-cycle counter: strips side-set bits from the delay field, loads on
// completion and counts down one per divider tick.
module pio_delay_counter
  import pio_pkg::*;
#(
  parameter int DELAY_W = PIO_DELAY_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic               dec,
  input  logic [DELAY_W-1:0] field,
  input  logic [2:0]         sideset_count,
  output logic [DELAY_W-1:0] load_val,
  output logic               last
);
  logic [DELAY_W-1:0] cnt;
  logic [DELAY_W-1:0] mask;
  int                 ss_sat;

  // side-set bits occupy the top of the field; counts above the field width saturate
  assign ss_sat = (int'(sideset_count) > DELAY_W) ? DELAY_W : int'(sideset_count);

  always_comb begin
    mask = '0;
    for (int i = 0; i < DELAY_W; i++)
      mask[i] = (i < (DELAY_W - ss_sat));
  end

  assign load_val = field & mask;
  assign last     = (cnt == DELAY_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/pio_sm_sequencer.sv
// Per-SM sequencer: picks the instruction slot (IMM > EXEC > MEM), handles
// stalls and delay ticks, and drives the program counter controls.
module pio_sm_sequencer
  import pio_pkg::*;
#(
  parameter int ADDR_W  = PIO_ADDR_W,
  parameter int INSTR_W = PIO_INSTR_W,
  parameter int DELAY_W = PIO_DELAY_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               penable,
  input  logic               restart,
  input  logic [2:0]         sideset_count,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               imm_valid,
  input  logic [INSTR_W-1:0] imm_instr,
  input  logic               exec_valid,
  input  logic [INSTR_W-1:0] exec_instr,
  input  logic               exec_stall,
  input  logic               jmp_taken,
  input  logic [ADDR_W-1:0]  jmp_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [1:0]         instr_src,
  output logic               pc_penable,
  output logic               pc_stalled,
  output logic               pc_jmp,
  output logic [ADDR_W-1:0]  pc_din,
  output logic               delaying
);
  state_e               state, state_nxt;
  src_e                 sel_src, held_src;
  logic                 imm_pend, exec_pend;
  logic [INSTR_W-1:0]   imm_reg, exec_reg, held_instr;
  logic                 tick, slot, complete, stall_now, delay_go, dly_last;
  logic [DELAY_W-1:0]   dly_val;

  // reset gates the tick so every 1-bit output reads 0 while reset_n is low
  assign tick      = en & penable & reset_n;
  assign slot      = tick & (state != ST_DELAY);
  assign complete  = slot & ~exec_stall;
  assign stall_now = slot & exec_stall;

  always_comb begin
    sel_src = SRC_MEM;
    instr   = mem_instr;
    if (imm_pend) begin
      sel_src = SRC_IMM;
      instr   = imm_reg;
    end else if (state == ST_STALL) begin
      sel_src = held_src;
      instr   = held_instr;
    end else if (exec_pend) begin
      sel_src = SRC_EXEC;
      instr   = exec_reg;
    end
  end

  pio_delay_counter #(.DELAY_W(DELAY_W)) u_dly (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (restart),
    .load         (delay_go & ~restart),
    .dec          (tick & (state == ST_DELAY)),
    .field        (instr[DELAY_LSB +: DELAY_W]),
    .sideset_count(sideset_count),
    .load_val     (dly_val),
    .last         (dly_last)
  );

  // forced instructions never take a delay
  assign delay_go = complete & (sel_src != SRC_IMM) & (dly_val != '0);

  assign instr_valid = slot;
  assign instr_src   = sel_src;
  assign pc_penable  = tick;
  assign pc_din      = jmp_addr;
  assign pc_jmp      = complete & jmp_taken;
  assign pc_stalled  = stall_now | (tick & (state == ST_DELAY)) |
                       (complete & (sel_src != SRC_MEM) & ~jmp_taken);
  assign delaying    = (state == ST_DELAY);

  always_comb begin
    state_nxt = state;
    if (restart)                                     state_nxt = ST_RUN;
    else if (stall_now)                              state_nxt = ST_STALL;
    else if (complete)                               state_nxt = delay_go ? ST_DELAY : ST_RUN;
    else if (tick && state == ST_DELAY && dly_last)  state_nxt = ST_RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imm_pend   <= 1'b0;
      imm_reg    <= '0;
      exec_pend  <= 1'b0;
      exec_reg   <= '0;
      held_instr <= '0;
      held_src   <= SRC_MEM;
    end else begin
      // a pending slot is consumed once issued, whether it completes or stalls
      if ((complete || stall_now) && sel_src == SRC_IMM) imm_pend <= 1'b0;
      if (imm_valid) begin
        imm_pend <= 1'b1;
        imm_reg  <= imm_instr;
      end
      if (restart) begin
        exec_pend <= 1'b0;
      end else begin
        if ((complete || stall_now) && sel_src == SRC_EXEC) exec_pend <= 1'b0;
        if (complete && exec_valid) begin
          exec_pend <= 1'b1;
          exec_reg  <= exec_instr;
        end
      end
      if (stall_now) begin
        held_instr <= instr;
        held_src   <= sel_src;
      end
    end
  end
endmodule
